// File: rtl/merge_tree_dispatch_buf_if.sv
// AXI-Stream beat bundle feeding the merge-tree dispatch buffer.
//   tvalid/tready : beat handshake
//   tdata         : packed records, record k at [k*REC_W +: REC_W]
//   tkeep         : one bit per record, contiguous from bit 0
//   tlast         : final beat of a run
// master drives the beat, slave returns tready.
interface merge_tree_dispatch_buf_if #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 8
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/merge_tree_dispatch_buf.sv
// Rate converter from a wide AXI-Stream beat to one merge-tree leaf.
// Each beat carries N_REC records; they are presented one per i_read as a
// first-word-fall-through source. A two-slot buffer (current A, prefetch B)
// gives zero-bubble beat transitions and a registered tready.
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_init_pass        : tag last on every 2^i_chunk_log2 records
//   i_chunk_log2       : log2 of the initial chunk, 0..LOG_N_REC
//   s_axis             : input beat stream (slave side)
//   i_read             : leaf pops the presented record
//   o_data             : {last_flag, record}
//   o_data_vld         : o_data valid
//   o_err              : sticky error, set on empty or non-contiguous tkeep
module merge_tree_dispatch_buf #(
  parameter int  AXIS_TDATA_WIDTH  = 512,
  parameter int  RECORD_DATA_WIDTH = 64,
  localparam int N_REC             = AXIS_TDATA_WIDTH / RECORD_DATA_WIDTH,
  localparam int LOG_N_REC         = $clog2(N_REC),
  localparam int CHUNK_W           = $clog2(LOG_N_REC + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_init_pass,
  input  logic [CHUNK_W-1:0]           i_chunk_log2,
  merge_tree_dispatch_buf_if.slave     s_axis,
  input  logic                         i_read,
  output logic [RECORD_DATA_WIDTH:0]   o_data,
  output logic                         o_data_vld,
  output logic                         o_err
);

  localparam int CNT_W = LOG_N_REC + 1;
  localparam logic [N_REC-1:0]     KEEP_ONE = N_REC'(1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [LOG_N_REC-1:0] IDX_ONE  = LOG_N_REC'(1);

  // Slot A: record currently presented; slot B: prefetched beat.
  logic [AXIS_TDATA_WIDTH-1:0] a_data_reg, a_data_next;
  logic [AXIS_TDATA_WIDTH-1:0] b_data_reg, b_data_next;
  logic [CNT_W-1:0]            a_cnt_reg, a_cnt_next;
  logic [CNT_W-1:0]            b_cnt_reg, b_cnt_next;
  logic                        a_last_reg, a_last_next;
  logic                        b_last_reg, b_last_next;
  logic                        a_vld_reg, a_vld_next;
  logic                        b_vld_reg, b_vld_next;
  logic [LOG_N_REC-1:0]        a_idx_reg, a_idx_next;
  logic                        err_reg, err_next;

  logic [CNT_W-1:0]             in_cnt;
  logic                         in_legal;
  logic                         hs;
  logic                         accept;
  logic                         pop;
  logic                         a_at_end;
  logic                         a_drain;
  logic                         to_a;
  logic                         last_flag;
  logic [RECORD_DATA_WIDTH-1:0] a_rec [N_REC];
  logic [LOG_N_REC-1:0]         chunk_mask;

  generate
    for (genvar gi = 0; gi < N_REC; gi++) begin : g_rec
      assign a_rec[gi] = a_data_reg[gi*RECORD_DATA_WIDTH +: RECORD_DATA_WIDTH];
    end
    // Low i_chunk_log2 bits of the index set: M = 2^chunk - 1.
    for (genvar gi = 0; gi < LOG_N_REC; gi++) begin : g_mask
      assign chunk_mask[gi] = (CHUNK_W'(gi) < i_chunk_log2);
    end
  endgenerate

  // Record count and legality of the incoming beat. A keep of the form
  // 0..01..1 has no carry overlap with itself plus one.
  always_comb begin
    in_cnt = '0;
    for (int k = 0; k < N_REC; k++) begin
      in_cnt = in_cnt + CNT_W'(s_axis.tkeep[k]);
    end
    in_legal = (s_axis.tkeep != '0) &&
               ((s_axis.tkeep & (s_axis.tkeep + KEEP_ONE)) == '0);
  end

  // tready depends only on registered B occupancy (and reset).
  assign s_axis.tready = i_rst_n & ~b_vld_reg;

  assign hs       = s_axis.tvalid & s_axis.tready;
  assign accept   = hs & in_legal;
  assign pop      = i_read & a_vld_reg;
  assign a_at_end = ({1'b0, a_idx_reg} == (a_cnt_reg - CNT_ONE));
  assign a_drain  = pop & a_at_end;
  // A takes the new beat when it is (or is becoming) free with nothing queued in B.
  assign to_a     = ~a_vld_reg | (a_drain & ~b_vld_reg);

  always_comb begin
    a_data_next = a_data_reg;
    a_cnt_next  = a_cnt_reg;
    a_last_next = a_last_reg;
    a_vld_next  = a_vld_reg;
    a_idx_next  = a_idx_reg;
    b_data_next = b_data_reg;
    b_cnt_next  = b_cnt_reg;
    b_last_next = b_last_reg;
    b_vld_next  = b_vld_reg;
    err_next    = err_reg;

    if (pop && !a_at_end) begin
      a_idx_next = a_idx_reg + IDX_ONE;
    end

    if (a_drain) begin
      a_vld_next = 1'b0;
      a_idx_next = '0;
      if (b_vld_reg) begin
        a_data_next = b_data_reg;
        a_cnt_next  = b_cnt_reg;
        a_last_next = b_last_reg;
        a_vld_next  = 1'b1;
        b_vld_next  = 1'b0;
      end
    end

    // B valid forces tready low, so an accept never collides with B->A reload.
    if (accept) begin
      if (to_a) begin
        a_data_next = s_axis.tdata;
        a_cnt_next  = in_cnt;
        a_last_next = s_axis.tlast;
        a_vld_next  = 1'b1;
        a_idx_next  = '0;
      end else begin
        b_data_next = s_axis.tdata;
        b_cnt_next  = in_cnt;
        b_last_next = s_axis.tlast;
        b_vld_next  = 1'b1;
      end
    end

    if (hs && !in_legal) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a_vld_reg <= 1'b0;
      b_vld_reg <= 1'b0;
      a_idx_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      a_vld_reg <= a_vld_next;
      b_vld_reg <= b_vld_next;
      a_idx_reg <= a_idx_next;
      err_reg   <= err_next;
    end
  end

  // Payload registers are qualified by the valid bits and need no reset.
  always_ff @(posedge i_clk) begin
    a_data_reg <= a_data_next;
    a_cnt_reg  <= a_cnt_next;
    a_last_reg <= a_last_next;
    b_data_reg <= b_data_next;
    b_cnt_reg  <= b_cnt_next;
    b_last_reg <= b_last_next;
  end

  assign last_flag  = (a_last_reg & a_at_end) |
                      (i_init_pass & ((a_idx_reg & chunk_mask) == chunk_mask));
  assign o_data     = {last_flag, a_rec[a_idx_reg]};
  assign o_data_vld = i_rst_n & a_vld_reg;
  assign o_err      = err_reg;

endmodule

// File: tb/tb_merge_tree_dispatch_buf.sv
module tb_merge_tree_dispatch_buf;
  localparam int TW = 512;
  localparam int RW = 64;
  localparam int NR = 8;
  localparam int CW = 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_init_pass = 1'b0;
  logic [CW-1:0] i_chunk_log2 = '0;
  logic          i_read = 1'b0;
  logic [RW:0]   o_data;
  logic          o_data_vld;
  logic          o_err;

  merge_tree_dispatch_buf_if #(.DATA_W(TW), .KEEP_W(NR)) axis ();

  merge_tree_dispatch_buf #(
    .AXIS_TDATA_WIDTH (TW),
    .RECORD_DATA_WIDTH(RW)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_init_pass (i_init_pass),
    .i_chunk_log2(i_chunk_log2),
    .s_axis      (axis.slave),
    .i_read      (i_read),
    .o_data      (o_data),
    .o_data_vld  (o_data_vld),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  logic [RW:0] exp_q[$];
  int total = 0;
  int bad = 0;
  bit rand_done;

  task automatic check(input string name, input logic [RW:0] act, input logic [RW:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timeout", name);
  endtask

  // Reference model: a legal keep is a run of ones from bit 0; each kept
  // record is queued with its last flag from the run-end and chunk rules.
  task automatic model_push(input logic [TW-1:0] d, input logic [NR-1:0] k, input logic l);
    int  n = 0;
    bit  legal = 1;
    bit  seen_zero = 0;
    int  chunk = 1 << i_chunk_log2;
    for (int b = 0; b < NR; b++) begin
      if (k[b]) begin
        if (seen_zero) legal = 0;
        n++;
      end else begin
        seen_zero = 1;
      end
    end
    if (n == 0) legal = 0;
    if (legal) begin
      for (int r = 0; r < n; r++) begin
        logic flag;
        flag = (l && r == n - 1) || (i_init_pass && (r % chunk) == chunk - 1);
        exp_q.push_back({flag, d[r*RW +: RW]});
      end
    end
  endtask

  task automatic send_beat(input logic [TW-1:0] d, input logic [NR-1:0] k, input logic l);
    bit ok = 0;
    axis.tvalid = 1'b1;
    axis.tdata  = d;
    axis.tkeep  = k;
    axis.tlast  = l;
    for (int c = 0; c < 200; c++) begin
      @(negedge i_clk);
      if (axis.tready) begin
        model_push(d, k, l);
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("beat_accept");
    @(posedge i_clk);
    #1;
    axis.tvalid = 1'b0;
    $display("beat keep=%h last=%0d accepted=%0d", k, l, ok);
  endtask

  task automatic drain(input string name);
    bit ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0 && !o_data_vld) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout(name);
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [TW-1:0] rand_beat();
    logic [TW-1:0] d;
    for (int w = 0; w < TW / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  // Monitor: every pop is compared against the scoreboard head.
  always @(negedge i_clk) begin
    if (i_rst_n && o_data_vld && i_read) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop actual=%h required=none", o_data);
      end else begin
        logic [RW:0] e;
        e = exp_q.pop_front();
        $display("pop data=%h", o_data);
        check("record", o_data, e);
      end
    end
  end

  initial begin
    logic [TW-1:0] d1;
    int run;
    axis.tvalid = 1'b0;
    axis.tdata  = '0;
    axis.tkeep  = '0;
    axis.tlast  = 1'b0;

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_vld", o_data_vld, 0);
    check("rst_ready", axis.tready, 0);
    check("rst_err", o_err, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("ready_after_rst", axis.tready, 1);
    @(posedge i_clk);
    #1;

    // Single beat 0x10..0x17, tlast
    for (int r = 0; r < NR; r++) d1[r*RW +: RW] = RW'(64'h10 + r);
    i_read = 1'b1;
    send_beat(d1, 8'hFF, 1'b1);
    check("first_vld", o_data_vld, 1);
    check("first_rec", o_data, {1'b0, 64'h10});
    drain("single_drain");

    // Back-to-back streaming: 32 cycles with no bubble, tready probed mid-cycle
    fork
      begin
        for (int b = 0; b < 4; b++) send_beat(rand_beat(), 8'hFF, b == 3);
      end
      begin
        bit seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
          @(negedge i_clk);
          seen = o_data_vld;
        end
        run = 0;
        while (o_data_vld && run < 64) begin
          run++;
          @(negedge i_clk);
        end
        check("no_bubble_run", 65'(run), 65'(32));
      end
      begin
        for (int c = 0; c < 6; c++) begin
          logic rd;
          @(posedge i_clk);
          #2;
          rd = axis.tready;
          i_read = 1'b0;
          #1;
          check("ready_vs_read", axis.tready, rd);
          i_read = 1'b1;
        end
      end
    join
    drain("stream_drain");

    // Backpressure: only two beats fit, record 0 of beat 1 held
    i_read = 1'b0;
    d1 = rand_beat();
    fork
      begin
        send_beat(d1, 8'hFF, 1'b0);
        send_beat(rand_beat(), 8'hFF, 1'b0);
        send_beat(rand_beat(), 8'hFF, 1'b1);
      end
      begin
        repeat (6) @(negedge i_clk);
        check("bp_ready", axis.tready, 0);
        check("bp_vld", o_data_vld, 1);
        check("bp_hold", o_data, {1'b0, d1[RW-1:0]});
        check("bp_queued", 65'(exp_q.size()), 65'(16));
        @(posedge i_clk);
        #1;
        i_read = 1'b1;
      end
    join
    drain("bp_drain");

    // Init pass chunk sizes
    i_init_pass = 1'b1;
    for (int ch = 0; ch < 4; ch++) begin
      if (ch != 1) begin
        i_chunk_log2 = CW'(ch);
        send_beat(rand_beat(), 8'hFF, 1'b0);
        drain("init_drain");
      end
    end
    i_init_pass  = 1'b0;
    i_chunk_log2 = '0;

    // Partial and illegal tkeep
    send_beat(rand_beat(), 8'h07, 1'b1);
    drain("partial_drain");
    check("err_before", o_err, 0);
    send_beat(rand_beat(), 8'h00, 1'b1);
    @(negedge i_clk);
    check("err_zero_keep", o_err, 1);
    send_beat(rand_beat(), 8'h0B, 1'b0);
    drain("illegal_drain");
    send_beat(rand_beat(), 8'h01, 1'b1);
    drain("legal_after_err");
    check("err_sticky", o_err, 1);

    // Randomized traffic with random leaf reads
    rand_done = 0;
    fork
      begin
        for (int b = 0; b < 24; b++) begin
          logic [8:0] t;
          logic [NR-1:0] k;
          t = (9'h1 << $urandom_range(1, NR)) - 9'h1;
          k = t[NR-1:0];
          if ($urandom_range(0, 5) == 0) k = NR'($urandom_range(0, 255));
          send_beat(rand_beat(), k, 1'($urandom_range(0, 1)));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge i_clk);
          #1;
          i_read = 1'($urandom_range(0, 1));
        end
        i_read = 1'b1;
      end
    join
    drain("random_drain");

    // Reset mid-run after 3 pops of a buffered 2-beat run
    i_read = 1'b0;
    send_beat(rand_beat(), 8'hFF, 1'b0);
    send_beat(rand_beat(), 8'hFF, 1'b1);
    i_read = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_read = 1'b0;
    check("pops_before_rst", 65'(exp_q.size()), 65'(13));
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    check("midrst_vld", o_data_vld, 0);
    check("midrst_ready", axis.tready, 0);
    exp_q.delete();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("midrst_vld_after", o_data_vld, 0);
    check("midrst_err_clear", o_err, 0);
    @(posedge i_clk);
    #1;
    i_read = 1'b1;
    d1 = rand_beat();
    send_beat(d1, 8'hFF, 1'b1);
    check("fresh_rec0", o_data, {1'b0, d1[RW-1:0]});
    drain("fresh_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/merge_tree_dispatch_buf.md
Name: merge_tree_dispatch_buf

Overview:
Parametrised rate converter between a wide AXI-Stream input and one merge-tree leaf. It unpacks N_REC = AXIS_TDATA_WIDTH/RECORD_DATA_WIDTH records per beat and presents them one per i_read as a first-word-fall-through source. It adds a two-beat buffer, giving zero-bubble beat transitions and an s_axis_tready independent of i_read. It also adds record-granular tkeep for partial final beats and a runtime-selectable initial chunk size for last-flag tagging.

Parameters:
AXIS_TDATA_WIDTH, 512, input beat width; multiple of RECORD_DATA_WIDTH.
RECORD_DATA_WIDTH, 64, record width; N_REC = AXIS_TDATA_WIDTH/RECORD_DATA_WIDTH must be a power of two ≥ 2.
(derived) LOG_N_REC = $clog2(N_REC); CHUNK_W = $clog2(LOG_N_REC+1).

Ports:
i_clk  in  1  clock; all logic on the rising edge.
i_rst_n  in  1  synchronous active-low reset.
i_init_pass  in  1  initial pass: tag a last flag every 2^i_chunk_log2 records.
i_chunk_log2  in  CHUNK_W  log2 of the initial sorted chunk; legal values 0..LOG_N_REC.
s_axis_tvalid  in  1  input beat valid.
s_axis_tready  out  1  input beat accepted.
s_axis_tdata  in  AXIS_TDATA_WIDTH  record k occupies bits [k*RECORD_DATA_WIDTH +: RECORD_DATA_WIDTH].
s_axis_tkeep  in  N_REC  one bit per record; bit k set means record k is valid.
s_axis_tlast  in  1  final beat of a run.
i_read  in  1  leaf pops the current record.
o_data  out  RECORD_DATA_WIDTH+1  {last_flag, record}.
o_data_vld  out  1  o_data is valid.
o_err  out  1  sticky protocol error.

Behaviour:
- Storage
  - Slot A (current): data, cnt (number of valid records), tlast bit, idx (LOG_N_REC bits).
  - Slot B (prefetch): data, cnt, tlast bit.
  - Each slot has a valid bit.
- Reset (i_rst_n = 0 at an edge): A and B invalid, idx = 0, o_err = 0.
  - o_data_vld = 0 and s_axis_tready = 0 while i_rst_n is low.
  - Reset mid-run discards all buffered records.
- Ready: s_axis_tready = i_rst_n & ~B_vld. It is purely registered state, with no combinational path from i_read or s_axis_tvalid.
- Accept: a handshake occurs when s_axis_tvalid & s_axis_tready.
  - cnt = popcount(tkeep).
  - tkeep must be contiguous from bit 0 (e.g. 0x0F is legal, 0x0B is not).
  - Zero-tkeep or non-contiguous tkeep: the beat is dropped (including its tlast) and o_err is set.
- Routing of an accepted beat:
  - It goes to A if A is empty, or if A is being emptied this cycle and B is empty.
  - Otherwise it goes to B.
- Pop: a pop occurs when i_read & o_data_vld. i_read while o_data_vld = 0 is ignored.
  - If idx < cnt-1, idx increments.
  - Otherwise A is emptied, idx returns to 0, and A reloads from B (B emptied) or from the same-cycle incoming beat, per the routing rule.
- Output
  - o_data_vld = A_vld.
  - o_data[RECORD_DATA_WIDTH-1:0] = A.data[idx].
  - last_flag = (A.tlast & idx == cnt-1) | (i_init_pass & (idx & M) == M), where M = (1<<i_chunk_log2)-1.
  - i_chunk_log2 = 0 gives last on every record. i_chunk_log2 = LOG_N_REC gives last on record N_REC-1 only.
- Latency and throughput
  - Beat accepted at edge t with the buffer empty: o_data_vld = 1 after edge t, record 0 is presented.
  - Sustained one pop per cycle with s_axis_tvalid held high: no bubble across beat boundaries.
- Simultaneous events
  - Pop of the final record of A, B empty, and a handshake in the same cycle: the new beat goes directly to A. o_data_vld stays 1 and shows new record 0 the next cycle.
  - Handshake and pop while B is valid cannot occur, because tready = 0.
- Quasi-static inputs: i_init_pass and i_chunk_log2 change only while o_data_vld = 0. Behaviour is otherwise undefined.
- Partial beat: tkeep = 0x07 with tlast presents 3 records; record 2 carries last.

Test Plan:
- Reset then single beat: tdata records 0..7 = 0x10..0x17, tkeep = 0xFF, tlast = 1, i_read held 1.
  - Required: o_data_vld rises 1 cycle after the handshake.
  - Outputs 0x10..0x17 on consecutive cycles; last_flag only on 0x17; o_data_vld then drops.
- Back-to-back streaming: 4 beats with tvalid continuous and i_read = 1.
  - Required: 32 consecutive valid cycles with no bubble, records in order.
  - s_axis_tready never depends combinationally on i_read (check by toggling i_read mid-cycle in the bench).
- Backpressure: i_read = 0 and 3 beats offered.
  - Required: 2 beats accepted, then tready = 0; o_data holds record 0 of beat 1.
  - Releasing i_read drains all 16 records in order, and the third beat is accepted once B frees.
- Init pass: i_init_pass = 1, i_chunk_log2 = 2, one beat with no tlast.
  - Required: last_flag on idx 3 and idx 7 only.
  - With i_chunk_log2 = 0, every record is flagged.
- Partial and illegal tkeep: tkeep = 0x07 with tlast gives 3 records, last on the third.
  - tkeep = 0x00 or 0x0B: beat dropped, o_err = 1 and sticky until i_rst_n = 0.
- Reset mid-run: assert i_rst_n = 0 after 3 pops of a buffered 2-beat run.
  - Required: next cycle o_data_vld = 0 and tready = 0.
  - After release, a fresh beat is output starting at its record 0.
